// File: rtl/gessm_mul_arbiter.sv
// Round-robin front end sharing one 16x16 segmented approximate multiplier
// (n=16, m=8, q=5) across NREQ requesters; two register stages, ID-tagged results.

module gessm_mul_seg (
  input  logic [15:0] x,
  output logic [7:0]  seg,
  output logic [3:0]  sh
);
  always_comb begin
    seg = x[7:0];
    sh  = 4'd0;
    if (|x[15:13]) begin
      seg = x[15:8];
      sh  = 4'd8;
    end else if (|x[12:8]) begin
      seg = x[12:5];
      sh  = 4'd5;
    end
  end
endmodule

module gessm_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id
);

  typedef struct packed {
    logic [7:0]     seg_a;
    logic [7:0]     seg_b;
    logic [4:0]     sh;
    logic [IDW-1:0] id;
  } s1_t;

  // vld_pipe_q[1] = S1 occupancy, vld_pipe_q[2] = rsp_valid
  logic [2:1]     vld_pipe_q, vld_pipe_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  s1_t            s1_q, s1_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           adv1, adv2, xfer;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand, nxt;

  logic [1:0][15:0] op;
  logic [1:0][7:0]  seg;
  logic [1:0][3:0]  sh;
  logic [15:0]      p16;
  logic [31:0]      prod;

  assign adv2 = !vld_pipe_q[2] | rsp_ready;
  assign adv1 = !vld_pipe_q[1] | adv2;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  assign xfer = adv1 & gnt_vld & !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  assign op[0] = req_a[16*gnt_idx +: 16];
  assign op[1] = req_b[16*gnt_idx +: 16];

  for (genvar l = 0; l < 2; l++) begin : g_seg
    gessm_mul_seg u_seg (.x(op[l]), .seg(seg[l]), .sh(sh[l]));
  end

  assign p16  = 16'(s1_q.seg_a) * 16'(s1_q.seg_b);
  assign prod = {16'b0, p16} << s1_q.sh;

  always_comb begin
    nxt        = {1'b0, gnt_idx} + (IDW+1)'(1);
    if (nxt == (IDW+1)'(NREQ)) nxt = '0;
    ptr_d      = xfer ? nxt[IDW-1:0] : ptr_q;
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (adv1) begin
      vld_pipe_d[1] = gnt_vld;
      if (gnt_vld) s1_d = '{seg_a: seg[0], seg_b: seg[1],
                            sh: 5'(sh[0]) + 5'(sh[1]), id: gnt_idx};
    end
    if (adv2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      rsp_data_d    = prod;
      rsp_id_d      = s1_q.id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      ptr_q      <= '0;
      s1_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ptr_q      <= ptr_d;
      s1_q       <= s1_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = vld_pipe_q[2];
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_gessm_mul_arbiter.sv
// Directed bench for gessm_mul_arbiter: products, round-robin order, stalls, async reset.

module tb_gessm_mul_arbiter;
  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  int n_chk, n_fail;

  gessm_mul_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic send0(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
    set_op(0, a, b);
    req_valid = 4'b0001;
    #1 chk({tag, "_rdy"}, 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    chk({tag, "_lat"}, 32'(rsp_valid), 32'h0);
    step();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'h1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_id"}, 32'(rsp_id), 32'h0);
    step();
  endtask

  initial begin
    clk = 0; rst = 1; rsp_ready = 1;
    req_valid = 4'b0001; req_a = '0; req_b = '0;
    n_chk = 0; n_fail = 0;

    #12;
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    @(negedge clk); rst = 0; req_valid = 0;
    step();

    send0("exact",  16'h0012, 16'h0034, 32'h000003A8);
    send0("mid",    16'h0100, 16'h0003, 32'h00000300);
    send0("top",    16'h2345, 16'h0010, 32'h00023000);
    send0("max",    16'hFFFF, 16'hFFFF, 32'hFE010000);
    send0("zero_a", 16'h0000, 16'h1234, 32'h0);
    send0("zero_b", 16'hABCD, 16'h0000, 32'h0);

    // Stall with S1 empty: exactly one more accept, then none.
    set_op(0, 16'h0012, 16'h0034);
    rsp_ready = 0; req_valid = 4'b0001;
    step();
    req_valid = 0;
    step();
    set_op(1, 16'h0003, 16'h0005);
    req_valid = 4'b0010;
    #1 chk("stE_rdy1", 32'(req_ready), 32'h2);
    step();
    chk("stE_rdy0", 32'(req_ready), 0);
    chk("stE_hold", rsp_data, 32'h3A8);
    req_valid = 0; rsp_ready = 1;
    step();
    chk("stE_id", 32'(rsp_id), 1);
    chk("stE_data", rsp_data, 32'hF);
    step();
    chk("stE_empty", 32'(rsp_valid), 0);

    // Fairness skip: ptr is now 2, only 1 and 3 valid.
    req_valid = 4'b1010;
    #1 chk("skip_g0", 32'(req_ready), 32'h8);
    step();
    chk("skip_g1", 32'(req_ready), 32'h2);
    step();
    chk("skip_g2", 32'(req_ready), 32'h8);
    step();
    req_valid = 0;
    chk("skip_id", 32'(rsp_id), 1);
    step(); step(); step();

    // Round robin from a fresh pointer.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0010);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1 chk("rr_rdy", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk("rr_vld", 32'(rsp_valid), 1);
        chk("rr_id", 32'(rsp_id), 32'((c - 2) % 4));
        chk("rr_data", rsp_data, 32'(16 * ((c - 2) % 4 + 1)));
      end
      step();
    end

    // Backpressure under full load: S2 holds id0, S1 holds id1.
    rsp_ready = 0;
    for (int s = 0; s < 5; s++) begin
      #1 chk("bp_rdy", 32'(req_ready), 0);
      chk("bp_id", 32'(rsp_id), 0);
      chk("bp_data", rsp_data, 32'h10);
      step();
    end
    rsp_ready = 1;
    #1 chk("bp_rel_rdy", 32'(req_ready), 32'h4);
    step();
    chk("bp_rel_rdy2", 32'(req_ready), 32'h8);
    req_valid = 0;
    for (int s = 1; s <= 2; s++) begin
      chk("bp_drain_id", 32'(rsp_id), 32'(s));
      chk("bp_drain_data", rsp_data, 32'(16 * (s + 1)));
      step();
    end
    chk("bp_drain_end", 32'(rsp_valid), 0);

    // Async reset mid-stream.
    req_valid = 4'b1111;
    step(); step();
    chk("ar_pre_vld", 32'(rsp_valid), 1);
    #2 rst = 1;
    #1 chk("ar_vld", 32'(rsp_valid), 0);
    chk("ar_rdy", 32'(req_ready), 0);
    chk("ar_data", rsp_data, 0);
    step();
    #3 rst = 0; req_valid = 4'b0100;
    #1 chk("ar_g2", 32'(req_ready), 32'h4);
    chk("ar_novld", 32'(rsp_valid), 0);
    step();
    chk("ar_novld2", 32'(rsp_valid), 0);
    req_valid = 4'b1001;
    #1 chk("ar_ptr3", 32'(req_ready), 32'h8);
    step();
    req_valid = 0;
    chk("ar_id2", 32'(rsp_id), 2);
    chk("ar_data2", rsp_data, 32'h30);
    step();
    chk("ar_id3", 32'(rsp_id), 3);
    chk("ar_data3", rsp_data, 32'h40);
    step();
    chk("ar_end", 32'(rsp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
